// File: rtl/ifetch_pkg.sv
// Shared widths, types and helpers for the instruction fetch slice.
package ifetch_pkg;
  localparam int ADDR_W = 5;
  localparam int DATA_W = 32;

  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] word_t;

  function automatic addr_t pc_next(addr_t pc);
    return pc + addr_t'(1);
  endfunction
endpackage

// File: rtl/fetch_skid.sv
// Two-entry in-order buffer between the instruction RAM response and decode.
module fetch_skid
  import ifetch_pkg::*;
#(
  parameter int DW = DATA_W
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] push_data_i,
  input  addr_t         push_pc_i,
  input  logic          pop_i,
  input  logic          flush_i,
  output logic          valid_o,
  output logic [DW-1:0] data_o,
  output addr_t         pc_o,
  output logic [1:0]    count_o
);
  logic          v0_q, v0_d, v1_q, v1_d;
  logic [DW-1:0] d0_q, d0_d, d1_q, d1_d;
  addr_t         p0_q, p0_d, p1_q, p1_d;
  logic          pop;

  assign pop = pop_i && v0_q;

  always_comb begin
    v0_d = v0_q;
    v1_d = v1_q;
    d0_d = d0_q;
    d1_d = d1_q;
    p0_d = p0_q;
    p1_d = p1_q;
    if (flush_i) begin
      v0_d = 1'b0;
      v1_d = 1'b0;
    end else if (pop) begin
      // head advances; a simultaneous push lands behind whatever remains
      d0_d = d1_q;
      p0_d = p1_q;
      v0_d = v1_q;
      v1_d = 1'b0;
      if (push_i) begin
        if (v1_q) begin
          d1_d = push_data_i;
          p1_d = push_pc_i;
          v1_d = 1'b1;
        end else begin
          d0_d = push_data_i;
          p0_d = push_pc_i;
          v0_d = 1'b1;
        end
      end
    end else if (push_i) begin
      if (!v0_q) begin
        d0_d = push_data_i;
        p0_d = push_pc_i;
        v0_d = 1'b1;
      end else begin
        d1_d = push_data_i;
        p1_d = push_pc_i;
        v1_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_q <= 1'b0;
      v1_q <= 1'b0;
      d0_q <= '0;
      d1_q <= '0;
      p0_q <= '0;
      p1_q <= '0;
    end else begin
      v0_q <= v0_d;
      v1_q <= v1_d;
      d0_q <= d0_d;
      d1_q <= d1_d;
      p0_q <= p0_d;
      p1_q <= p1_d;
    end
  end

  assign valid_o = v0_q;
  assign data_o  = d0_q;
  assign pc_o    = p0_q;
  assign count_o = {1'b0, v0_q} + {1'b0, v1_q};
endmodule

// File: rtl/ifetch.sv
// Instruction fetch: sequential PC, one-cycle RAM latency, redirect, 2-entry output buffer.
module ifetch
  import ifetch_pkg::addr_t;
  import ifetch_pkg::pc_next;
#(
  parameter addr_t RESET_PC = 5'd0,
  parameter int    DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  output addr_t             mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [DATA_W-1:0] inst_data,
  output addr_t             inst_pc,
  input  logic              redirect,
  input  addr_t             redirect_pc
);
  logic       run_q;
  logic       inflight_q;
  addr_t      inflight_pc_q;
  addr_t      fetch_pc_q, fetch_pc_d;
  logic [1:0] occ;
  logic [2:0] load;
  logic       pop, issue;

  assign pop  = inst_valid && inst_ready;
  assign load = {1'b0, occ} + {2'b00, inflight_q};
  // at most one entry may remain committed after this cycle's pop, so a new response always fits
  assign issue = run_q && !redirect && (load <= ({2'b00, pop} + 3'd1));

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (redirect) fetch_pc_d = redirect_pc;
    else if (issue) fetch_pc_d = pc_next(fetch_pc_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q         <= 1'b0;
      fetch_pc_q    <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= '0;
    end else begin
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= issue;
      if (issue) inflight_pc_q <= fetch_pc_q;
    end
  end

  assign mem_addr = fetch_pc_q;

  fetch_skid #(.DW(DATA_W)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .push_i     (inflight_q),
    .push_data_i(mem_data),
    .push_pc_i  (inflight_pc_q),
    .pop_i      (pop),
    .flush_i    (redirect),
    .valid_o    (inst_valid),
    .data_o     (inst_data),
    .pc_o       (inst_pc),
    .count_o    (occ)
  );
endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter: RESET_PC, 5'd0, first instruction address fetched after reset.
REQ-002 Parameter: DATA_W, 32, instruction width; address width fixed at 5 (32-word instruction RAM).
REQ-003 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-004 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-005 Port: mem_addr  output  5  read address to instruction RAM; the RAM registers it and returns data one cycle later.
REQ-006 Port: mem_data  input  DATA_W  RAM read data; corresponds to mem_addr of the previous cycle.
REQ-007 Port: inst_valid  output  1  inst_data/inst_pc hold a fetched instruction.
REQ-008 Port: inst_ready  input  1  decode accepts the instruction; transfer when inst_valid && inst_ready.
REQ-009 Port: inst_data  output  DATA_W  fetched instruction word.
REQ-010 Port: inst_pc  output  5  address inst_data was read from.
REQ-011 Port: redirect  input  1  branch/jump taken; restart fetch at redirect_pc.
REQ-012 Port: redirect_pc  input  5  new fetch address, sampled when redirect=1.

Function
REQ-013 Cycle k = interval after edge k; fetch_pc register drives mem_addr directly (registered output).
REQ-014 Issue in cycle k when redirect=0 and (occupancy + inflight - pop) <= 1, where occupancy = buffer entries (0..2), inflight = request issued in cycle k-1 not dropped, pop = inst_valid && inst_ready.
REQ-015 On issue, fetch_pc increments mod 32 (31 -> 0) at edge k+1; no issue, fetch_pc holds.
REQ-016 Inflight flag and its pc are registered at edge k+1 from issue; mem_data in cycle k+1 is the response for that pc.
REQ-017 Valid response in cycle k is written into the 2-entry in-order buffer at edge k+1; it is visible on inst_* in cycle k+1 at the earliest.
REQ-018 Buffer head drives inst_valid/inst_data/inst_pc; pop removes head at the edge; simultaneous push and pop allowed at any occupancy.
REQ-019 Buffer never overflows; response never arrives when occupancy=2 without a pop in that cycle (guaranteed by REQ-014).
REQ-020 With inst_ready held 1 and no redirect, one instruction per cycle is delivered, pcs consecutive mod 32.
REQ-021 With inst_ready=0, inst_valid and inst_* stay stable until accepted; no instruction dropped or duplicated.
REQ-022 Redirect has priority: at edge k+1, fetch_pc <= redirect_pc, buffer flushed, inflight cleared (response in cycle k+1 discarded), no issue in cycle k.
REQ-023 A pop in the same cycle as redirect counts as a completed transfer; all other buffered entries are discarded.
REQ-024 Redirect latency: redirect in cycle k -> mem_addr=redirect_pc in cycle k+1 -> inst_valid=1, inst_pc=redirect_pc in cycle k+3.
REQ-025 Back-to-back redirects: only the last one takes effect; each restarts REQ-024 timing.
REQ-026 inst_data/inst_pc are don't-care while inst_valid=0.
REQ-027 State: RUN only after first edge post-reset; no other FSM states; redirect to current fetch_pc behaves identically to any redirect.

Reset
REQ-028 rst_n=0 asynchronously forces: fetch_pc=RESET_PC (mem_addr=RESET_PC), inflight=0, occupancy=0, inst_valid=0, inst_data=0, inst_pc=0.
REQ-029 Reset mid-operation discards all buffered and inflight instructions; after release, first issue in cycle 0, inst_valid=1 with inst_pc=RESET_PC in cycle 2.

Structure
REQ-030 Shared package holds ADDR_W=5, DATA_W=32 and the word type used by ram and ifetch.
REQ-031 Buffer is sub-module fetch_skid: 2-entry FIFO, push/pop/flush, async active-low reset, data+pc per entry.
REQ-032 ifetch contains only fetch_pc, inflight flag/pc, issue logic and the fetch_skid instance.

Verification
REQ-033 Bench pairs ifetch with the instruction RAM model, mem[i]=32'hA000_0000+i.
REQ-034 Reset release, inst_ready=1 -> cycle 2 inst_pc=0/inst_data=A0000000, then 1,2,... one per cycle, 31 followed by 0.
REQ-035 inst_ready=0 for 5 cycles from cycle 4 -> inst_pc=2 held stable, occupancy 2, mem_addr frozen; on release 2,3,4 delivered with no gap or duplicate.
REQ-036 redirect=1, redirect_pc=20 in cycle 6 -> mem_addr=20 in cycle 7, inst_valid=0 cycles 7-8, inst_pc=20/data=A0000014 in cycle 9.
REQ-037 Redirect coincident with accepted pop, buffer full -> popped instruction counted once, other entry never appears; next pc after flush is redirect_pc.
REQ-038 rst_n pulsed low mid-stream with buffer full -> outputs zero immediately; after release sequence restarts at RESET_PC as REQ-034.
